fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width matching the FIFO DSIZE.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum words per grant (1..15).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1  clock; the FIFO write-domain clock (i_wclk of the FIFO).
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_valid  in  NREQ  per-requester word-valid.
REQ-008 i_data  in  NREQ*DSIZE  per-requester data; requester k occupies bits [k*DSIZE +: DSIZE].
REQ-009 o_ready  out  NREQ  per-requester ready; a transfer occurs when i_valid[k] & o_ready[k] are both high.
REQ-010 o_wr  out  1  FIFO write strobe (drives FIFO i_wr).
REQ-011 o_wdata  out  DSIZE  FIFO write data (drives FIFO i_wdata).
REQ-012 i_wfull  in  1  FIFO full flag (from FIFO o_wfull).
REQ-013 o_grant  out  NREQ  registered one-hot grant; all-zero when idle.
REQ-014 o_busy  out  1  high while in state GRANT.

Function
REQ-015 SHALL implement FSM states IDLE and GRANT, held in registers.
REQ-016 IDLE: o_grant = 0; if any i_valid is high, the next state is GRANT with o_grant set to the selected requester on the next edge (one-cycle arbitration latency).
REQ-017 Selection SHALL be round-robin: search from (last_granted+1) mod NREQ upward, wrapping, and take the first requester with i_valid high.
REQ-018 GRANT, granted index g: o_ready[g] = ~i_wfull; all other o_ready bits are 0.
REQ-019 o_wr = i_valid[g] & ~i_wfull & (state==GRANT), combinational, with zero-cycle pass-through.
REQ-020 o_wdata = i_data slice g while in GRANT; it is 0 in IDLE.
REQ-021 Burst counter: cleared on each new grant and incremented on each transfer; width is $clog2(MAX_BURST+1).
REQ-022 The grant SHALL be released at the clock edge where either i_valid[g] is low, or a transfer occurs with the counter at MAX_BURST-1.
REQ-023 On release: if any other requester (excluding g) has i_valid high, move directly GRANT->GRANT to the next round-robin winner; otherwise go to IDLE.
REQ-024 If i_valid[g] is the only valid at release due to burst limit, g SHALL be re-granted (GRANT->GRANT) with the counter cleared.
REQ-025 While i_wfull is high: no transfer, counter frozen, grant held unless i_valid[g] drops.
REQ-026 last_granted SHALL update to g each time a grant is issued.
REQ-027 SHALL never write while i_wfull is high, and SHALL never assert more than one o_grant or o_ready bit.

Reset
REQ-028 While i_rst is high at an edge: state=IDLE, o_grant=0, counter=0, last_granted=NREQ-1 (requester 0 has first priority).
REQ-029 During and after reset until the first grant: o_wr=0, o_ready=0, o_wdata=0, o_busy=0.
REQ-030 Reset mid-burst SHALL abort the grant at that edge; no partial state is retained.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the default parameter constants.
REQ-032 Sub-module rr_picker (combinational: request vector, last index -> one-hot winner, found flag) SHALL implement selection.

Verification
REQ-033 Reset then i_valid=4'b0001, data 0x10..0x17, wfull=0 -> grant 0001 one cycle later; words 0x10-0x13 written; 1-cycle re-grant; 0x14-0x17 written.
REQ-034 All four valid continuously, MAX_BURST=4 -> grant order 0,1,2,3,0; exactly 4 o_wr pulses per grant; no cycle with two grant bits.
REQ-035 Requester 2 streaming, i_wfull high for 5 cycles mid-burst -> o_wr=0 and o_ready=0 for those 5 cycles; counter holds; the burst resumes with the remaining words.
REQ-036 Requester 1 drops valid after 2 words while requester 3 is valid -> next edge grant moves to 3 with no IDLE cycle.
REQ-037 Assert i_rst during a burst -> next edge o_grant=0, o_wr=0; after release requester 0 wins over 1 when both are valid.
REQ-038 End-to-end with the FIFO (DEPTH 16) and a slow reader -> every word is read back in per-requester order, with no overflow.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_DSIZE     = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first requester above 'last', wrapping, wins.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   win_idx,
  output logic            found
);

  logic [IW-1:0] idx;

  // Scan outward from last+1 and keep only the first hit.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(last) + i) % NREQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Multiplexes NREQ valid/ready word sources onto one FIFO write port,
// granting one requester at a time in round-robin order with bursts
// capped at MAX_BURST words.
//
// state | meaning
// IDLE  | no grant held; arbitrate among valid requesters
// GRANT | one requester owns the FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_valid,
  input  logic [NREQ*DSIZE-1:0] i_data,
  output logic [NREQ-1:0]       o_ready,
  output logic                  o_wr,
  output logic [DSIZE-1:0]      o_wdata,
  input  logic                  i_wfull,
  output logic [NREQ-1:0]       o_grant,
  output logic                  o_busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_RESET = IW'(NREQ - 1);

  arb_state_t    state;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   last;
  logic [CW-1:0]   cnt;

  logic            busy;
  logic            valid_g;
  logic            xfer;
  logic            burst_end;
  logic            release_g;
  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] pick_win;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;

  assign busy      = (state == GRANT);
  assign valid_g   = |(i_valid & grant);
  assign xfer      = busy & valid_g & ~i_wfull;
  assign burst_end = xfer & (cnt == LAST_BEAT);
  assign release_g = busy & (~valid_g | burst_end);

  // While granted, the current owner is masked so a release hands off to
  // someone else whenever anyone else is waiting.
  assign pick_req = busy ? (i_valid & ~grant) : i_valid;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (pick_req),
    .last    (last),
    .winner  (pick_win),
    .win_idx (pick_idx),
    .found   (pick_found)
  );

  assign o_ready = (busy & ~i_wfull) ? grant : '0;
  assign o_wr    = xfer;
  assign o_grant = grant;
  assign o_busy  = busy;

  // Write-data mux driven by the one-hot grant; zero when nothing is granted.
  always_comb begin
    o_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) o_wdata = o_wdata | i_data[k*DSIZE +: DSIZE];
    end
  end

  // Grant FSM with burst counter and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      grant <= '0;
      cnt   <= '0;
      last  <= LAST_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= GRANT;
            grant <= pick_win;
            last  <= pick_idx;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (release_g) begin
            if (pick_found) begin
              grant <= pick_win;
              last  <= pick_idx;
              cnt   <= '0;
            end else if (burst_end) begin
              // Sole requester hit the burst cap: re-grant it in place.
              cnt <= '0;
            end else begin
              state <= IDLE;
              grant <= '0;
              cnt   <= '0;
            end
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
